radix4_booth_datapath: RTL



---
 rtl/radix4_booth_datapath.sv | 89 ++++++++
 1 files changed

// File: rtl/radix4_booth_datapath.sv
// radix4_booth_datapath: radix-4 Booth multiplier datapath, one Booth digit retired per enabled clock.
// Build option: define RADIX4_BOOTH_UNSIGNED_EN for unsigned operands (one extra Booth step).
module radix4_booth_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               start_booth,
  input  logic               en_booth,
  input  logic               rst_cntr_n,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               done_cntr
);

  localparam int AW = WIDTH + 2;
`ifdef RADIX4_BOOTH_UNSIGNED_EN
  localparam int QW     = WIDTH + 2;
  localparam int NSTEPS = WIDTH / 2 + 1;
`else
  localparam int QW     = WIDTH;
  localparam int NSTEPS = WIDTH / 2;
`endif
  localparam int PW = AW + QW + 1;
  localparam int CW = $clog2(NSTEPS + 1);

  logic signed [AW-1:0] a_p0;
  logic signed [PW-1:0] p_p0;
  logic [CW-1:0]        cnt_p0;

  logic signed [AW-1:0] a_ext;
  logic [QW-1:0]        q_ext;
  logic signed [AW-1:0] acc_sum;
  logic signed [PW-1:0] p_step;
  logic                 step;

  // Booth digit recoding: {q1, q0, q_m1} selects 0, +-A or +-2A.
  function automatic logic signed [AW-1:0] booth_addend(
    input logic [2:0]           sel,
    input logic signed [AW-1:0] a
  );
    case (sel)
      3'b001, 3'b010: booth_addend = a;
      3'b011:         booth_addend = a <<< 1;
      3'b100:         booth_addend = -(a <<< 1);
      3'b101, 3'b110: booth_addend = -a;
      default:        booth_addend = '0;
    endcase
  endfunction

`ifdef RADIX4_BOOTH_UNSIGNED_EN
  assign a_ext = {2'b00, multiplicand};
  assign q_ext = {2'b00, multiplier};
`else
  assign a_ext = {{2{multiplicand[WIDTH-1]}}, multiplicand};
  assign q_ext = multiplier;
`endif

  // Accumulate in the upper field, then shift the whole P register right by one digit.
  assign acc_sum   = p_p0[PW-1 -: AW] + booth_addend(p_p0[2:0], a_p0);
  assign p_step    = $signed({acc_sum, p_p0[QW:0]}) >>> 2;
  assign done_cntr = (cnt_p0 == CW'(NSTEPS));
  assign step      = en_booth & ~done_cntr;
  assign product   = p_p0[2*WIDTH:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0   <= '0;
      p_p0   <= '0;
      cnt_p0 <= '0;
    end else if (en) begin
      if (start_booth) begin
        a_p0   <= a_ext;
        p_p0   <= {{AW{1'b0}}, q_ext, 1'b0};
        cnt_p0 <= '0;
      end else begin
        if (!rst_cntr_n)
          cnt_p0 <= '0;
        else if (step)
          cnt_p0 <= cnt_p0 + 1'b1;
        if (step)
          p_p0 <= p_step;
      end
    end
  end

endmodule
